// File: rtl/if_stage_pip.sv
// Instruction-fetch stage: owns the PC, drives a one-outstanding-request
// instruction-memory handshake and holds the IF/ID pipeline register.
// A word that arrives while decode is stalled is parked in r_buf; a redirect
// that arrives while a request is in flight waits in DISCARD for the stale
// response before the target is fetched.
module if_stage_pip #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_id_write,
    input  logic        if_id_flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic        fetch_stall
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic [31:0] r_pc_out;
    logic [31:0] r_instr_out;
    logic        r_valid_out;
    logic        r_fetch_stall;

    logic [31:0] w_target;
    logic [31:0] w_pc_inc;
    logic        w_avail;
    logic        w_deliver;
    logic [31:0] w_word;
    logic        w_issue;
    logic [31:0] w_issue_addr;
    state_t      w_state_next;
    logic [31:0] w_pc_next;
    logic        w_buf_load;

    // Target is always word aligned; masking keeps every input bit in use.
    assign w_target  = redirect_pc & 32'hFFFF_FFFC;
    assign w_pc_inc  = r_pc + 32'd4;
    assign w_avail   = ((r_state == S_WAIT) && imem_valid) || (r_state == S_HOLD);
    assign w_deliver = if_id_write & ~if_id_flush & ~redirect & w_avail;
    assign w_word    = (r_state == S_HOLD) ? r_buf : imem_rdata;

    // Fetch control: decide this cycle's request and the next PC/state.
    always_comb begin
        w_issue      = 1'b0;
        w_issue_addr = r_pc;
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_buf_load   = 1'b0;
        case (r_state)
            S_REQ: begin
                w_issue      = 1'b1;
                w_issue_addr = redirect ? w_target : r_pc;
                w_pc_next    = redirect ? w_target : r_pc;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (redirect) begin
                    w_pc_next = w_target;
                    if (imem_valid) begin
                        // Stale word returns now: drop it and fetch the target.
                        w_issue      = 1'b1;
                        w_issue_addr = w_target;
                    end else begin
                        w_state_next = S_DISCARD;
                    end
                end else if (imem_valid) begin
                    if (w_deliver) begin
                        w_issue      = 1'b1;
                        w_issue_addr = w_pc_inc;
                        w_pc_next    = w_pc_inc;
                    end else begin
                        w_buf_load   = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_issue      = 1'b1;
                    w_issue_addr = w_target;
                    w_pc_next    = w_target;
                    w_state_next = S_WAIT;
                end else if (w_deliver) begin
                    w_issue      = 1'b1;
                    w_issue_addr = w_pc_inc;
                    w_pc_next    = w_pc_inc;
                    w_state_next = S_WAIT;
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    w_pc_next = w_target;
                end
                if (imem_valid) begin
                    // Stale response consumed; the pending address may be fetched now.
                    w_issue      = 1'b1;
                    w_issue_addr = redirect ? w_target : r_pc;
                    w_state_next = S_WAIT;
                end
            end
            default: begin
                w_state_next = S_REQ;
            end
        endcase
    end

    assign imem_req  = w_issue & ~rst;
    assign imem_addr = w_issue_addr;

    // Fetch state, pending PC and the stall buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_buf   <= 32'h0000_0000;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_buf_load) begin
                r_buf <= imem_rdata;
            end
        end
    end

    // IF/ID register: flush beats load, load beats bubble, stall holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_out      <= 32'h0000_0000;
            r_instr_out   <= NOP_INSTR;
            r_valid_out   <= 1'b0;
            r_fetch_stall <= 1'b0;
        end else if (if_id_flush) begin
            r_pc_out      <= 32'h0000_0000;
            r_instr_out   <= NOP_INSTR;
            r_valid_out   <= 1'b0;
            r_fetch_stall <= 1'b0;
        end else if (if_id_write) begin
            if (w_deliver) begin
                r_pc_out      <= r_pc;
                r_instr_out   <= w_word;
                r_valid_out   <= 1'b1;
                r_fetch_stall <= 1'b0;
            end else begin
                r_pc_out      <= 32'h0000_0000;
                r_instr_out   <= NOP_INSTR;
                r_valid_out   <= 1'b0;
                r_fetch_stall <= ~w_avail;
            end
        end else begin
            r_fetch_stall <= 1'b0;
        end
    end

    assign pc_out      = r_pc_out;
    assign instr_out   = r_instr_out;
    assign valid_out   = r_valid_out;
    assign fetch_stall = r_fetch_stall;

endmodule

// File: tb/tb_if_stage_pip.sv
// Bench for if_stage_pip: a latency-programmable instruction memory model,
// a cycle-exact vector table for the directed corner cases and a randomized
// run checked against an expected fetch-stream model.
module tb_if_stage_pip;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] MASK = 32'hA5A5_0000;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_id_write;
    logic        if_id_flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;
    logic        fetch_stall;

    always #5 clk = ~clk;

    if_stage_pip #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_id_write (if_id_write),
        .if_id_flush (if_id_flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
        .valid_out   (valid_out),
        .fetch_stall (fetch_stall)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        rst_v;
        logic        w;
        logic        f;
        logic        r;
        logic [31:0] rp;
        int          lat;
        logic        e_req;
        logic [31:0] e_addr;
        logic        chk;
        logic        e_v;
        logic [31:0] e_pc;
        logic        e_fs;
    } vec_t;

    mreq_t mem_q[$];
    vec_t  vecs[$];
    vec_t  exp_q[$];
    int    cyc;
    int    lat_min;
    int    lat_max;
    int    n_checks;
    int    n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst_v, input logic w, input logic f, input logic r,
                                input logic [31:0] rp, input int lat, input logic e_req,
                                input logic [31:0] e_addr, input logic chk, input logic e_v,
                                input logic [31:0] e_pc, input logic e_fs);
        vec_t v;
        v.rst_v = rst_v; v.w = w; v.f = f; v.r = r; v.rp = rp; v.lat = lat;
        v.e_req = e_req; v.e_addr = e_addr; v.chk = chk; v.e_v = e_v;
        v.e_pc = e_pc; v.e_fs = e_fs;
        return v;
    endfunction

    // One clock: memory response for this cycle, then the stage inputs,
    // then capture any request the stage issues.
    task automatic run_cycle(input logic rst_v, input logic w, input logic f,
                             input logic r, input logic [31:0] rp);
        mreq_t m;
        @(posedge clk);
        #1;
        cyc++;
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF ^ 32'(cyc);
        if (rst_v) begin
            mem_q.delete();
        end else if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            m = mem_q.pop_front();
            imem_valid = 1'b1;
            imem_rdata = m.addr ^ MASK;
        end
        rst         = rst_v;
        if_id_write = w;
        if_id_flush = f;
        redirect    = r;
        redirect_pc = rp;
        #1;
        if (!rst_v && imem_req) begin
            check("one_outstanding", 32'(mem_q.size()), 32'd0);
            m.addr = imem_addr;
            m.due  = cyc + int'($urandom_range(lat_max, lat_min));
            mem_q.push_back(m);
        end
    endtask

    vec_t        v;
    vec_t        e;
    logic [31:0] exp_pc;
    logic        prev_w;
    logic        prev_f;
    logic        prev_rst;
    logic        rw;
    logic        rf;
    logic        rr;
    logic [31:0] rrp;
    int          delivered;

    initial begin
        rst = 1'b1; if_id_write = 1'b0; if_id_flush = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imem_valid = 1'b0; imem_rdata = 32'h0;
        cyc = 0; lat_min = 1; lat_max = 1; n_checks = 0; n_errors = 0;

        // rst, w, f, r, rp, lat | e_req, e_addr | chk, e_v, e_pc, e_fs
        vecs.push_back(mk(Y,N,N,N,32'h0,1, N,32'h0, N,N,32'h0,N));
        vecs.push_back(mk(Y,N,N,N,32'h0,1, N,32'h0, N,N,32'h0,N));
        // 1-cycle memory: streaming, 3-cycle stall, flush, same-cycle redirect
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_0000, Y,N,32'h0,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_0004, Y,N,32'h0,Y));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_0008, Y,Y,32'h0000_0000,N));
        vecs.push_back(mk(N,N,N,N,32'h0,1, N,32'h0,         Y,Y,32'h0000_0004,N));
        vecs.push_back(mk(N,N,N,N,32'h0,1, N,32'h0,         Y,Y,32'h0000_0004,N));
        vecs.push_back(mk(N,N,N,N,32'h0,1, N,32'h0,         Y,Y,32'h0000_0004,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_000C, Y,Y,32'h0000_0004,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_0010, Y,Y,32'h0000_0008,N));
        vecs.push_back(mk(N,Y,Y,N,32'h0,1, N,32'h0,         Y,Y,32'h0000_000C,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_0014, Y,N,32'h0,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_0018, Y,Y,32'h0000_0010,N));
        vecs.push_back(mk(N,Y,N,Y,32'h0000_0200,1, Y,32'h0000_0200, Y,Y,32'h0000_0014,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_0204, Y,N,32'h0,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_0208, Y,Y,32'h0000_0200,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_020C, Y,Y,32'h0000_0204,N));
        vecs.push_back(mk(N,Y,N,Y,32'h0000_0303,1, Y,32'h0000_0300, Y,Y,32'h0000_0208,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_0304, Y,N,32'h0,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_0308, Y,Y,32'h0000_0300,N));
        // reset with a request in flight, then 3-cycle memory and redirect while waiting
        vecs.push_back(mk(Y,Y,N,N,32'h0,3, N,32'h0, N,N,32'h0,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,3, Y,32'h0000_0000, Y,N,32'h0,N));
        vecs.push_back(mk(N,Y,N,Y,32'h0000_0100,3, N,32'h0, Y,N,32'h0,Y));
        vecs.push_back(mk(N,Y,N,N,32'h0,3, N,32'h0,         Y,N,32'h0,Y));
        vecs.push_back(mk(N,Y,N,N,32'h0,3, Y,32'h0000_0100, Y,N,32'h0,Y));
        vecs.push_back(mk(N,Y,N,N,32'h0,3, N,32'h0,         Y,N,32'h0,Y));
        vecs.push_back(mk(N,Y,N,N,32'h0,3, N,32'h0,         Y,N,32'h0,Y));
        vecs.push_back(mk(N,Y,N,N,32'h0,3, Y,32'h0000_0104, Y,N,32'h0,Y));
        vecs.push_back(mk(N,Y,N,N,32'h0,3, N,32'h0,         Y,Y,32'h0000_0100,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,3, N,32'h0,         Y,N,32'h0,Y));
        vecs.push_back(mk(N,Y,N,N,32'h0,3, Y,32'h0000_0108, Y,N,32'h0,Y));
        vecs.push_back(mk(N,Y,N,N,32'h0,3, N,32'h0,         Y,Y,32'h0000_0104,N));
        // PC wrap at the top of the address space
        vecs.push_back(mk(Y,Y,N,N,32'h0,1, N,32'h0, N,N,32'h0,N));
        vecs.push_back(mk(N,Y,N,Y,32'hFFFF_FFF8,1, Y,32'hFFFF_FFF8, Y,N,32'h0,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'hFFFF_FFFC, Y,N,32'h0,Y));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_0000, Y,Y,32'hFFFF_FFF8,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_0004, Y,Y,32'hFFFF_FFFC,N));
        vecs.push_back(mk(N,Y,N,N,32'h0,1, Y,32'h0000_0008, Y,Y,32'h0000_0000,N));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            lat_min = v.lat;
            lat_max = v.lat;
            exp_q.push_back(v);
            run_cycle(v.rst_v, v.w, v.f, v.r, v.rp);
            e = exp_q.pop_front();
            check("imem_req", 32'(imem_req), 32'(e.e_req));
            if (e.e_req) check("imem_addr", imem_addr, e.e_addr);
            if (e.chk) begin
                check("valid_out", 32'(valid_out), 32'(e.e_v));
                check("pc_out", pc_out, e.e_pc);
                check("instr_out", instr_out, e.e_v ? (e.e_pc ^ MASK) : NOP);
                check("fetch_stall", 32'(fetch_stall), 32'(e.e_fs));
            end
        end

        // Randomized run: variable latency, stalls, flushes and redirects.
        lat_min = 1;
        lat_max = 3;
        run_cycle(Y, N, N, N, 32'h0);
        exp_pc = 32'h0;
        prev_w = N; prev_f = N; prev_rst = Y;
        delivered = 0;
        for (int i = 0; i < 500; i++) begin
            rw  = ($urandom_range(0, 4) != 0);
            rf  = ($urandom_range(0, 19) == 0);
            rr  = ($urandom_range(0, 24) == 0);
            rrp = 32'($urandom_range(0, 4095));
            run_cycle(N, rw, rf, rr, rrp);
            if (!prev_rst && !prev_f && prev_w && valid_out) begin
                check("stream_pc", pc_out, exp_pc);
                check("stream_instr", instr_out, exp_pc ^ MASK);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (!valid_out) begin
                check("bubble_instr", instr_out, NOP);
                check("bubble_pc", pc_out, 32'h0);
            end
            if (rr) exp_pc = rrp & 32'hFFFF_FFFC;
            prev_w = rw; prev_f = rf; prev_rst = N;
        end
        check("stream_progress", 32'(delivered >= 60), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
